// File: rtl/rf_pkg.sv
// Shared types and sizing helpers for the single-port register file and its interface.
package rf_pkg;

    typedef enum logic [2:0] {
        CLR  = 3'd0,
        IDLE = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        DONE = 3'd4
    } rf_state_t;

    localparam logic [31:0] RF_ZERO = 32'h0000_0000;

    function automatic int RF_DEPTH(input bit embedded);
        return embedded ? 16 : 32;
    endfunction

    function automatic int RF_AW(input bit embedded);
        return embedded ? 4 : 5;
    endfunction

endpackage

// File: rtl/rf_drsw_intf.sv
// Operand-fetch bundle between the decode sequencer (to_rf) and the register file (from_rf).
interface rf_drsw_intf #(
    parameter bit embedded = 1'b1
);
    import rf_pkg::*;

    localparam int AW = RF_AW(embedded);

    logic [AW-1:0] RdAddr;
    logic [AW-1:0] Rs1Addr;
    logic [AW-1:0] Rs2Addr;
    logic [31:0]   RdData;
    logic [31:0]   Rs1Data;
    logic [31:0]   Rs2Data;

    modport from_rf (
        input  RdAddr, Rs1Addr, Rs2Addr, RdData,
        output Rs1Data, Rs2Data
    );

    modport to_rf (
        output RdAddr, Rs1Addr, Rs2Addr, RdData,
        input  Rs1Data, Rs2Data
    );

endinterface

// File: rtl/rf_sp_ram.sv
// Single-port RAM: synchronous write, registered 1-cycle read, no reset.
// Kept behavioural so it can be swapped one-for-one with a vendor macro.
module rf_sp_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Array write and registered read share the one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/rf_sp_sweep_regfile.sv
// Register file on one single-port RAM; two operand reads serialised by a small FSM.
// Optional RF_CLEAR_ON_RESET_EN: zero-sweep of x1..xN-1 after reset release.
module rf_sp_sweep_regfile
    import rf_pkg::*;
#(
    parameter bit EMBEDDED = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    rf_drsw_intf.from_rf rf,
    input  logic         rd_we,
    input  logic         rs_req,
    output logic         rf_ready,
    output logic         rs_valid
);

    localparam int DEPTH = RF_DEPTH(EMBEDDED);
    localparam int AW    = RF_AW(EMBEDDED);
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

`ifdef RF_CLEAR_ON_RESET_EN
    localparam rf_state_t     RESET_STATE = CLR;
    localparam logic [AW-1:0] ADDR_ONE    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_LAST   = AW'(DEPTH - 1);
    logic [AW-1:0] clr_cnt_r;
`else
    localparam rf_state_t RESET_STATE = IDLE;
`endif

    rf_state_t     state_r, state_s;
    logic          ready_r, ready_s;
    logic          valid_r;
    logic [AW-1:0] rs1_addr_r, rs2_addr_r;
    logic [31:0]   hold_r;
    logic [31:0]   rs1_data_r, rs2_data_r;
    logic          ram_we_s;
    logic [AW-1:0] ram_addr_s;
    logic [31:0]   ram_wdata_s;
    logic [31:0]   ram_rdata_s;
    logic          accept_req_s;

    assign accept_req_s = (state_r == IDLE) && ready_r && rs_req;

    // Next state and RAM port arbitration between sweep, writes and operand reads.
    always_comb begin
        state_s     = state_r;
        ram_we_s    = 1'b0;
        ram_addr_s  = rf.RdAddr;
        ram_wdata_s = rf.RdData;
        case (state_r)
            CLR: begin
`ifdef RF_CLEAR_ON_RESET_EN
                ram_we_s    = 1'b1;
                ram_addr_s  = clr_cnt_r;
                ram_wdata_s = RF_ZERO;
                if (clr_cnt_r == ADDR_LAST) begin
                    state_s = IDLE;
                end else begin
                    state_s = CLR;
                end
`else
                state_s = IDLE;
`endif
            end
            IDLE: begin
                if (ready_r) begin
                    // x0 is hard-wired; the write lands before a same-cycle request reads it.
                    ram_we_s = rd_we && (rf.RdAddr != ADDR_ZERO);
                    if (rs_req) begin
                        state_s = RD1;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD1: begin
                ram_addr_s = rs1_addr_r;
                state_s    = RD2;
            end
            RD2: begin
                ram_addr_s = rs2_addr_r;
                state_s    = DONE;
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = RESET_STATE;
            end
        endcase
        // Ready stays low for the rs_valid cycle, giving one read per four cycles.
        ready_s = (state_s == IDLE) && (state_r != DONE);
    end

    // FSM state, handshake flags, latched addresses and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RESET_STATE;
            ready_r    <= 1'b0;
            valid_r    <= 1'b0;
            rs1_addr_r <= ADDR_ZERO;
            rs2_addr_r <= ADDR_ZERO;
            hold_r     <= RF_ZERO;
            rs1_data_r <= RF_ZERO;
            rs2_data_r <= RF_ZERO;
        end else begin
            state_r <= state_s;
            ready_r <= ready_s;
            valid_r <= (state_r == DONE);
            if (accept_req_s) begin
                rs1_addr_r <= rf.Rs1Addr;
                rs2_addr_r <= rf.Rs2Addr;
            end
            if (state_r == RD2) begin
                hold_r <= (rs1_addr_r == ADDR_ZERO) ? RF_ZERO : ram_rdata_s;
            end
            if (state_r == DONE) begin
                rs1_data_r <= hold_r;
                rs2_data_r <= (rs2_addr_r == ADDR_ZERO) ? RF_ZERO : ram_rdata_s;
            end
        end
    end

`ifdef RF_CLEAR_ON_RESET_EN
    // Sweep address counter; restarts from x1 on every reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_r <= ADDR_ONE;
        end else if (state_r == CLR) begin
            clr_cnt_r <= clr_cnt_r + ADDR_ONE;
        end else begin
            clr_cnt_r <= clr_cnt_r;
        end
    end
`endif

    rf_sp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (32),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    assign rf.Rs1Data = rs1_data_r;
    assign rf.Rs2Data = rs2_data_r;
    assign rf_ready   = ready_r;
    assign rs_valid   = valid_r;

endmodule

// File: tb/tb_rf_sp_sweep_regfile.sv
// Self-checking bench: directed cases plus random write/read traffic against an array model.
module tb_rf_sp_sweep_regfile;
    import rf_pkg::*;

    localparam bit EMBEDDED = 1'b1;
    localparam int DEPTH    = RF_DEPTH(EMBEDDED);
    localparam int AW       = RF_AW(EMBEDDED);
`ifdef RF_CLEAR_ON_RESET_EN
    localparam int READY_LAT = DEPTH - 1;
    localparam bit SWEEP     = 1'b1;
`else
    localparam int READY_LAT = 1;
    localparam bit SWEEP     = 1'b0;
`endif

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rd_we  = 1'b0;
    logic rs_req = 1'b0;
    logic rf_ready;
    logic rs_valid;

    int tests = 0;
    int fails = 0;

    logic [31:0] model [DEPTH];
    bit          known [DEPTH];

    rf_drsw_intf #(.embedded(EMBEDDED)) rf_if ();

    rf_sp_sweep_regfile #(.EMBEDDED(EMBEDDED)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rf       (rf_if),
        .rd_we    (rd_we),
        .rs_req   (rs_req),
        .rf_ready (rf_ready),
        .rs_valid (rs_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!rf_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rf_ready) check_eq("ready_timeout", 32'(rf_ready), 32'd1);
    endtask

    // Release reset at a negedge and time rf_ready; with the sweep the model becomes all-zero.
    task automatic release_and_time(inout bit saw_valid);
        int n = 0;
        rst_n = 1'b1;
        while (!rf_ready && n < 100) begin
            @(negedge clk);
            n++;
            saw_valid |= rs_valid;
        end
        check_eq("ready_after_reset", 32'(n), 32'(READY_LAT));
        if (SWEEP) begin
            for (int i = 0; i < DEPTH; i++) begin
                model[i] = 32'h0;
                known[i] = 1'b1;
            end
        end
    endtask

    function automatic logic [AW-1:0] safe_addr(input logic [AW-1:0] a);
        return known[a] ? a : {AW{1'b0}};
    endfunction

    // One handshake: optional write and/or read, with latency and pulse checks on reads.
    task automatic op(input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                      input logic req, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        int          lat;
        logic [31:0] e1, e2;
        wait_ready();
        rd_we = we;
        rs_req = req;
        rf_if.RdAddr = wa;
        rf_if.RdData = wd;
        rf_if.Rs1Addr = a1;
        rf_if.Rs2Addr = a2;
        @(negedge clk);
        rd_we = 1'b0;
        rs_req = 1'b0;
        if (we && wa != 0) begin
            model[wa] = wd;
            known[wa] = 1'b1;
        end
        if (req) begin
            e1 = (a1 == 0) ? 32'h0 : model[a1];
            e2 = (a2 == 0) ? 32'h0 : model[a2];
            lat = 0;
            while (!rs_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check_eq("read_latency", 32'(lat), 32'd3);
            check_eq("rs1_data", rf_if.Rs1Data, e1);
            check_eq("rs2_data", rf_if.Rs2Data, e2);
            check_eq("ready_low_in_valid", 32'(rf_ready), 32'd0);
            @(negedge clk);
            check_eq("valid_one_cycle", 32'(rs_valid), 32'd0);
            check_eq("ready_after_read", 32'(rf_ready), 32'd1);
            check_eq("rs1_hold", rf_if.Rs1Data, e1);
        end
    endtask

    initial begin
        bit          saw_valid;
        logic        we, req;
        logic [AW-1:0] wa, a1, a2;
        logic [31:0] wd;

        rf_if.RdAddr = '0;
        rf_if.Rs1Addr = '0;
        rf_if.Rs2Addr = '0;
        rf_if.RdData = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 32'h0;
            known[i] = 1'b0;
        end
        known[0] = 1'b1;

        repeat (3) @(negedge clk);
        check_eq("reset_ready", 32'(rf_ready), 32'd0);
        check_eq("reset_valid", 32'(rs_valid), 32'd0);
        check_eq("reset_rs1", rf_if.Rs1Data, 32'h0);
        check_eq("reset_rs2", rf_if.Rs2Data, 32'h0);
        saw_valid = 1'b0;
        release_and_time(saw_valid);
        check_eq("no_valid_after_reset", 32'(saw_valid), 32'd0);

        op(1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 4'd0);
        op(1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0, 4'd0, 4'd0);
        op(1'b1, 4'd7, 32'h1234_5678, 1'b0, 4'd0, 4'd0);
        op(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 4'd7);
        op(1'b1, 4'd3, 32'hA5A5_A5A5, 1'b1, 4'd3, 4'd3);
        op(1'b1, 4'd0, 32'hFFFF_FFFF, 1'b0, 4'd0, 4'd0);
        op(1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 4'd5);

        // Write strobed only while busy must be dropped.
        wait_ready();
        rs_req = 1'b1;
        rf_if.Rs1Addr = 4'd7;
        rf_if.Rs2Addr = 4'd3;
        @(negedge clk);
        rs_req = 1'b0;
        rd_we = 1'b1;
        rf_if.RdAddr = 4'd5;
        rf_if.RdData = 32'h0BAD_0BAD;
        repeat (3) @(negedge clk);
        check_eq("busy_read_valid", 32'(rs_valid), 32'd1);
        rd_we = 1'b0;
        op(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 4'd0);

        for (int k = 0; k < 80; k++) begin
            we  = 1'($urandom_range(0, 1));
            req = 1'($urandom_range(0, 1));
            wa  = AW'($urandom_range(0, DEPTH - 1));
            wd  = $urandom;
            a1  = AW'($urandom_range(0, DEPTH - 1));
            a2  = AW'($urandom_range(0, DEPTH - 1));
            if (!(we && a1 == wa)) a1 = safe_addr(a1);
            if (!(we && a2 == wa)) a2 = safe_addr(a2);
            op(we, wa, wd, req, a1, a2);
        end

        // Reset during RD2 aborts the read and clears the operands.
        op(1'b1, 4'd5, 32'h5555_0001, 1'b0, 4'd0, 4'd0);
        op(1'b1, 4'd7, 32'h7777_0001, 1'b1, 4'd5, 4'd7);
        wait_ready();
        rs_req = 1'b1;
        rf_if.Rs1Addr = 4'd5;
        rf_if.Rs2Addr = 4'd7;
        @(negedge clk);
        rs_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_rs1", rf_if.Rs1Data, 32'h0);
        check_eq("abort_rs2", rf_if.Rs2Data, 32'h0);
        check_eq("abort_ready", 32'(rf_ready), 32'd0);
        saw_valid = rs_valid;
        repeat (2) begin
            @(negedge clk);
            saw_valid |= rs_valid;
        end
        release_and_time(saw_valid);
        repeat (2) begin
            @(negedge clk);
            saw_valid |= rs_valid;
        end
        check_eq("abort_no_valid", 32'(saw_valid), 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            op(1'b0, 4'd0, 32'h0, 1'b1, safe_addr(AW'(i)), safe_addr(AW'(DEPTH - 1 - i)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_sp_sweep_regfile.md
# rf_sp_sweep_regfile

Register file that consumes the `from_rf` side of `rf_drsw_intf`, built on one single-port synchronous RAM so it maps to a single BRAM/SRAM macro. Two operand reads are serialised through the one port under a small FSM with a request/valid handshake. A single write port is shared with reads. It sits between the multicycle core's decode/operand-fetch sequencer, which drives `to_rf`, and the execute stage, which consumes `Rs1Data`/`Rs2Data`.

## Interface
Parameters:
- `EMBEDDED`, default 1; 1 = RV32E, 16 registers, 4-bit addresses; 0 = RV32I, 32 registers, 5-bit addresses. Must match the connected interface's `embedded`.

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rf`  interface  `rf_drsw_intf.from_rf`  carries the following:
  - inputs: `RdAddr`, `Rs1Addr`, `Rs2Addr`, `RdData`.
  - outputs: `Rs1Data`, `Rs2Data`, both registered.
- `rd_we`  in  1  write strobe; sampled only when `rf_ready`=1.
- `rs_req`  in  1  operand-read request; sampled only when `rf_ready`=1.
- `rf_ready`  out  1  block can accept `rd_we`/`rs_req` this cycle.
- `rs_valid`  out  1  one-cycle pulse; `Rs1Data`/`Rs2Data` hold the new operands.

## Operation
- States: `CLR` (macro only), `IDLE`, `RD1`, `RD2`, `DONE`.
- Reset values:
  - `rf_ready`=0, `rs_valid`=0, `Rs1Data`=`Rs2Data`=0.
  - State after reset: `CLR` if the macro is defined, else `IDLE`.
- `IDLE`:
  - `rf_ready`=1.
  - On `rd_we`: RAM[`RdAddr`] ← `RdData` at that edge. Writes with `RdAddr`=0 are suppressed.
  - On `rs_req`: latch `Rs1Addr`/`Rs2Addr`, go to `RD1`.
- Write and request in the same cycle:
  - Both are accepted.
  - The write lands first, so the reads return the new value (write-before-read).
- `RD1`: RAM addressed with latched rs1; go to `RD2`.
- `RD2`:
  - RAM output captured into rs1 holding register.
  - RAM addressed with latched rs2; go to `DONE`.
- `DONE`:
  - RAM output and rs1 holding register are loaded into `Rs2Data`/`Rs1Data`.
  - `rs_valid` pulses for the following cycle; return to `IDLE`.
- `rf_ready`=0 in `RD1`, `RD2`, `DONE` and `CLR`. `rd_we`/`rs_req` are ignored there, and the requester must hold them.
- x0 handling: a latched address of 0 forces the corresponding output to 32'h0, regardless of RAM contents.
- `Rs1Data`/`Rs2Data` hold their value between `rs_valid` pulses.
- Address width comes from `EMBEDDED`, so out-of-range addresses cannot occur.
- Reset asserted mid-read aborts: no `rs_valid` is produced and outputs return to 0. RAM contents are not reset, except via the sweep.

## Timing
- Request accepted at edge T0 (`IDLE`, `rs_req`=1).
- Next edges: `RD1` at T1, `RD2` at T2, `DONE` at T3.
- Outputs update at T3; `rs_valid`=1 in cycle T3..T4, and `rf_ready`=1 from T4.
- Read latency is 3 cycles; maximum throughput is one read per 4 cycles.
- Write latency is 1 cycle; back-to-back writes are allowed every cycle in `IDLE`.
- The RAM has a 1-cycle synchronous read; there is no combinational path from inputs to `Rs*Data`.

## Configuration
- `RF_CLEAR_ON_RESET_EN` defined:
  - After `rst_n` deasserts, `CLR` walks a counter 1..N-1 (N = 16 or 32), writing 0 one address per cycle.
  - `rf_ready` rises the cycle after the last write: 15 or 31 cycles after reset release.
  - Reset during the sweep restarts it from 1.
- Undefined:
  - No `CLR` state; `rf_ready`=1 from the first edge after reset release.
  - Unwritten registers read X in simulation and garbage in silicon.

## Structure
- Shared package `rf_pkg`:
  - `rf_state_t` enum.
  - `RF_DEPTH(embedded)` and `RF_AW(embedded)` constant functions.
  - `RF_ZERO` = 32'h0.
- Sub-module `rf_sp_ram`:
  - Parameterised depth/width, single port, sync write, 1-cycle sync read, no reset.
  - Swappable for a vendor macro.

## Test plan
- Reset then `rs_req` with rs1=0, rs2=0 → `rs_valid` 3 cycles later, both outputs 32'h0.
- Write x5=32'hDEAD_BEEF, x7=32'h1234_5678; read rs1=5, rs2=7 → `Rs1Data`=DEADBEEF and `Rs2Data`=12345678 at T3.
- Same cycle: `rd_we` x3=32'hA5A5_A5A5 and `rs_req` rs1=3, rs2=3 → both outputs A5A5A5A5.
- Write x0=32'hFFFF_FFFF, then read rs1=0 → 0. Drive `rd_we` while `rf_ready`=0 → the write is dropped, and a later read returns the old value.
- `rst_n` low during `RD2` → `rs_valid` never pulses and outputs are 0. With `RF_CLEAR_ON_RESET_EN` (EMBEDDED=1), `rf_ready` rises 15 cycles after release and all registers read 0.
